sw_debounce_edge: RTL
=====================

// Module: sw_debounce_edge
// PURPOSE
//   Front end for the slide-switch input bank. Synchronises and debounces every switch and
//   emits clean one-cycle rise/fall pulses plus an encoded "key event".
//   Sits between the board SW pins and the sequence-lock FSMs, which consume sw_level/sw_rise.
//   Switches already on at power-up or after reset never generate events.
// PARAMETERS
//   WIDTH            10       number of switch inputs
//   DEBOUNCE_CYCLES  500000   consecutive stable cycles before a level change is accepted (10 ms @ 50 MHz); min 2
//   CNT_W            $clog2(DEBOUNCE_CYCLES+2)  counter width (derived, localparam)
//   IDX_W            $clog2(WIDTH), min 1       event index width (derived, localparam)
// PORTS
//   clk          in   1      system clock
//   reset        in   1      asynchronous, active-high reset
//   sw_raw       in   WIDTH  raw asynchronous switch pins
//   ready        out  1      1 once INIT is complete and events are armed
//   sw_level     out  WIDTH  debounced switch level
//   sw_rise      out  WIDTH  one-cycle pulse per bit on a debounced 0->1 change
//   sw_fall      out  WIDTH  one-cycle pulse per bit on a debounced 1->0 change
//   event_valid  out  1      |sw_rise
//   event_idx    out  IDX_W  lowest-numbered bit set in sw_rise; 0 when event_valid=0
//   event_multi  out  1      more than one sw_rise bit set in the same cycle
// BEHAVIOUR
//   Reset: all flops clear; ready=0, sw_level=0, sw_rise=0, sw_fall=0, event_*=0; global FSM in INIT.
//   Synchroniser: 2-FF chain per bit (sync = sw_raw delayed 2 clk); reset value 0.
//   Global FSM:
//     INIT: sw_level loads sync every cycle; per-bit counters held at 0; rise/fall forced to 0;
//       init counter counts 0..DEBOUNCE_CYCLES+1, then -> RUN; ready=1 from the first RUN cycle.
//     RUN: per-bit debounce active; terminal state until reset.
//   Per-bit debounce in RUN:
//     - sync == sw_level: counter <= 0.
//     - sync != sw_level, counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
//     - sync != sw_level, counter == DEBOUNCE_CYCLES-1: sw_level <= sync, counter <= 0.
//       Also sw_rise (new level 1) or sw_fall (new level 0) <= 1 for that single next cycle.
//     - Any glitch back to the old level before the terminal count restarts the count from 0.
//     - Latency: a clean raw edge sets sw_level exactly 2+DEBOUNCE_CYCLES clk later.
//       The pulse is high in the same cycle sw_level first shows the new value.
//   sw_rise/sw_fall are registered; never both high on one bit; high for exactly 1 cycle per change.
//   Event encode (combinational from the sw_rise regs): event_valid, event_idx and event_multi
//   are valid in the same cycle as sw_rise. Priority is given to the lowest index.
//   Simultaneous rises: all bits pulse together, event_idx = lowest, event_multi=1.
//   The consumer treats that as a wrong key.
//   Bits are independent: a rise on one bit and a fall on another may occur in the same cycle.
//   Counter saturation is not reachable: counter max is DEBOUNCE_CYCLES-1 < 2^CNT_W.
//   Reset mid-debounce: the in-progress count is discarded and no pulse is emitted.
//   Levels re-acquire silently in INIT.
//   sw_level is the only debounced level source. Downstream uses sw_level[WIDTH-1]
//   (not raw SW) as its user reset.
// STRUCTURE
//   Shared package board_io_pkg:
//     SW_W=10, LED_W=10, HEX_W=7, SW_DEBOUNCE_DEFAULT=500000, HEX_BLANK=7'h7F.
//   Sub-module sw_debounce_bit (sync chain + counter + level + rise/fall regs).
//     Generate-instantiated WIDTH times with an en_run input from the global FSM.
//   Top level holds the INIT/RUN FSM, the init counter and the priority encoder / popcount>1.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, WIDTH=10)
//   1. Reset with sw_raw=10'h000, release -> ready rises 6 clk after reset release.
//      All outputs 0 until then.
//   2. Reset with sw_raw=10'h081 held -> after INIT sw_level=10'h081; sw_rise never pulses;
//      event_valid stays 0.
//   3. RUN, set sw_raw[7] 0->1 clean -> sw_level[7]=1 and sw_rise=10'h080 for 1 clk,
//      exactly 6 clk later; event_idx=7, event_multi=0.
//   4. RUN, toggle sw_raw[3] 1,0,1 with 2-clk gaps, then hold 1 -> a single sw_rise[3] pulse
//      4 clk after the last edge settles (+2 sync); no sw_fall[3].
//   5. RUN, raise sw_raw[2] and sw_raw[5] on the same clk -> sw_rise=10'h024 for 1 clk;
//      event_idx=2, event_multi=1.
//   6. RUN, start sw_raw[0] rise, assert reset at count 2 -> no pulse.
//      After release, INIT reloads sw_level[0]=1 silently.

Source files
------------

// File: rtl/board_io_pkg.sv
// Board I/O constants shared by the switch, LED and seven-segment front ends.
// Also holds the switch debouncer FSM state type and a width helper.
package board_io_pkg;
   localparam int         SW_W                = 10;
   localparam int         LED_W               = 10;
   localparam int         HEX_W               = 7;
   localparam int         SW_DEBOUNCE_DEFAULT = 500000;
   localparam logic [6:0] HEX_BLANK           = 7'h7F;

   typedef enum logic {
      DBN_INIT = 1'b0,
      DBN_RUN  = 1'b1
   } dbn_state_e;

   // Index width for an encoder over w inputs, never narrower than one bit.
   function automatic int idx_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction
endpackage

// File: rtl/sw_debounce_bit.sv
// One switch: 2-FF synchroniser, stability counter, debounced level and rise/fall pulse regs.
// Level follows raw 2+DEBOUNCE_CYCLES clk after a clean edge; no backpressure, pulses are one cycle.
module sw_debounce_bit #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   input  logic en_run,
   output logic level,
   output logic rise,
   output logic fall
);
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      s1_d    = raw;
      s2_d    = s1_q;
      level_d = level_q;
      cnt_d   = '0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (!en_run) begin
         // Outside RUN the level tracks the input so power-up state never looks like an edge.
         level_d = s2_q;
      end else if (s2_q != level_q) begin
         if (cnt_q == CNT_TERM) begin
            level_d = s2_q;
            rise_d  = s2_q;
            fall_d  = ~s2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;
endmodule

// File: rtl/sw_debounce_edge.sv
// Switch bank front end: INIT/RUN sequencing over per-bit debouncers plus rise-event encoder.
// Events appear in the same cycle as sw_rise; no backpressure, consumers must take every pulse.
module sw_debounce_edge
   import board_io_pkg::*;
#(
   parameter int  WIDTH           = SW_W,
   parameter int  DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
   localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 2),
   localparam int IDX_W           = idx_width(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_raw,
   output logic             ready,
   output logic [WIDTH-1:0] sw_level,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             event_valid,
   output logic [IDX_W-1:0] event_idx,
   output logic             event_multi
);
   localparam logic [CNT_W-1:0] INIT_TERM = CNT_W'(DEBOUNCE_CYCLES + 1);

   dbn_state_e       state_q, state_d;
   logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
   logic             en_run;

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      case (state_q)
         DBN_INIT: begin
            if (init_cnt_q == INIT_TERM) begin
               state_d = DBN_RUN;
            end else begin
               init_cnt_d = init_cnt_q + CNT_W'(1);
            end
         end
         DBN_RUN: state_d = DBN_RUN;
         default: state_d = DBN_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= DBN_INIT;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   assign en_run = (state_q == DBN_RUN);
   assign ready  = en_run;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      sw_debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_bit (
         .clk   (clk),
         .reset (reset),
         .raw   (sw_raw[g]),
         .en_run(en_run),
         .level (sw_level[g]),
         .rise  (sw_rise[g]),
         .fall  (sw_fall[g])
      );
   end

   // Descending scan so the lowest set bit is the last writer.
   always_comb begin
      event_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (sw_rise[i]) event_idx = IDX_W'(i);
      end
   end

   assign event_valid = |sw_rise;
   assign event_multi = |(sw_rise & (sw_rise - WIDTH'(1)));
endmodule
